// File: rtl/ps2_game_input_if.sv
// rtl/ps2_game_input_if.sv - PS/2 keyboard pins and game-control outputs of ps2_game_input.
interface ps2_game_input_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;
  logic       digit_valid;
  logic [3:0] digit_value;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  cursor_row, cursor_col, digit_valid, digit_value, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output cursor_row, cursor_col, digit_valid, digit_value, frame_error
  );
endinterface

// File: rtl/ps2_game_input.sv
// rtl/ps2_game_input.sv - PS/2 frame receiver and scan-code decoder driving a 9x9 cursor and digit entry.
module ps2_game_input #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  ps2_game_input_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic        clk_s1_q, clk_s2_q, clk_prev_q;
  logic        dat_s1_q, dat_s2_q;
  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        byte_valid_q, byte_valid_d;
  logic        ferr_q, ferr_d;
  logic        brk_q, brk_d, ext_q, ext_d;
  logic [3:0]  row_q, row_d, col_q, col_d;
  logic        dv_q, dv_d;
  logic [3:0]  dval_q, dval_d;
  logic        fall;

  assign fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      row_q        <= 4'd4;
      col_q        <= 4'd4;
      dv_q         <= 1'b0;
      dval_q       <= 4'd0;
    end else begin
      clk_s1_q     <= bus.ps2_clk;
      clk_s2_q     <= clk_s1_q;
      clk_prev_q   <= clk_s2_q;
      dat_s1_q     <= bus.ps2_data;
      dat_s2_q     <= dat_s1_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      ferr_q       <= ferr_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dv_q         <= dv_d;
      dval_q       <= dval_d;
    end
  end

  // Receive FSM; the watchdog only runs while a frame is in flight.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    ferr_d       = 1'b0;
    tmo_d        = (state_q == IDLE || fall) ? '0 : tmo_q + TW'(1);
    if (state_q != IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = dat_s2_q;
          state_d  = STOP;
        end
        default: begin
          if (dat_s2_q && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
          else                                     ferr_d       = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Scan-code decoder; the received byte stays in shift_q until the next frame starts.
  always_comb begin
    brk_d  = brk_q;
    ext_d  = ext_q;
    row_d  = row_q;
    col_d  = col_q;
    dv_d   = 1'b0;
    dval_d = dval_q;
    if (byte_valid_q) begin
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!brk_q && ext_q) begin
          case (shift_q)
            8'h75:   row_d = (row_q == 4'd0) ? 4'd8 : row_q - 4'd1;
            8'h72:   row_d = (row_q >= 4'd8) ? 4'd0 : row_q + 4'd1;
            8'h6B:   col_d = (col_q == 4'd0) ? 4'd8 : col_q - 4'd1;
            8'h74:   col_d = (col_q >= 4'd8) ? 4'd0 : col_q + 4'd1;
            default: ;
          endcase
        end else if (!brk_q) begin
          dv_d = 1'b1;
          case (shift_q)
            8'h16:        dval_d = 4'd1;
            8'h1E:        dval_d = 4'd2;
            8'h26:        dval_d = 4'd3;
            8'h25:        dval_d = 4'd4;
            8'h2E:        dval_d = 4'd5;
            8'h36:        dval_d = 4'd6;
            8'h3D:        dval_d = 4'd7;
            8'h3E:        dval_d = 4'd8;
            8'h46:        dval_d = 4'd9;
            8'h45, 8'h66: dval_d = 4'd0;
            default:      dv_d   = 1'b0;
          endcase
        end
      end
    end
  end

  assign bus.cursor_row  = row_q;
  assign bus.cursor_col  = col_q;
  assign bus.digit_valid = dv_q;
  assign bus.digit_value = dval_q;
  assign bus.frame_error = ferr_q;
endmodule

// File: tb/tb_ps2_game_input.sv
// tb/tb_ps2_game_input.sv - Scoreboard bench: directed PS/2 frames, monitor checks decoded events and latency.
module tb_ps2_game_input;
  localparam int TMO = 200;

  typedef struct {
    int kind;   // 0 digit, 1 frame error, 2 cursor move
    int a;
    int b;
    int lat;    // cycles after stop-bit clock fall; -1 = not timed
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ps2_game_input_if bus ();

  ps2_game_input #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   last_stop_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  int   prev_row = 4;
  int   prev_col = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int a, input int b, input int lat);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input int kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d (%0d,%0d) expected none", kind, a, b);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_a", a, e.a);
      chk("event_b", b, e.b);
      if (e.lat >= 0) chk("event_latency", cyc - last_stop_cyc, e.lat);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_row = int'(bus.cursor_row);
      prev_col = int'(bus.cursor_col);
    end else begin
      if (bus.digit_valid) match_ev(0, int'(bus.digit_value), 0);
      if (bus.frame_error) match_ev(1, 0, 0);
      if (int'(bus.cursor_row) != prev_row || int'(bus.cursor_col) != prev_col) begin
        match_ev(2, int'(bus.cursor_row), int'(bus.cursor_col));
        prev_row = int'(bus.cursor_row);
        prev_col = int'(bus.cursor_col);
      end
    end
  end

  function automatic logic [10:0] frame(input logic [7:0] b, input logic pflip, input logic stop);
    return {stop, (~^b) ^ pflip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      repeat (4) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) last_stop_cyc = cyc;
      repeat (4) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 1'b0, 1'b1), 11);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_row", int'(bus.cursor_row), 4);
    chk("reset_col", int'(bus.cursor_col), 4);
    chk("reset_digit_valid", int'(bus.digit_valid), 0);
    chk("reset_digit_value", int'(bus.digit_value), 0);
    chk("reset_frame_error", int'(bus.frame_error), 0);

    expect_ev(0, 1, 0, 4);
    send_byte(8'h16);

    r = 4;
    for (int k = 0; k < 5; k++) begin
      r = (r == 0) ? 8 : r - 1;
      expect_ev(2, r, 4, 4);
      send_byte(8'hE0);
      send_byte(8'h75);
    end

    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    expect_ev(0, 2, 0, 4);
    send_byte(8'h1E);

    expect_ev(1, 0, 0, 3);
    send_bits(frame(8'h26, 1'b1, 1'b1), 11);
    expect_ev(1, 0, 0, 3);
    send_bits(frame(8'h26, 1'b0, 1'b0), 11);

    expect_ev(1, 0, 0, -1);
    send_bits(frame(8'h5A, 1'b0, 1'b1), 4);
    repeat (TMO + 50) @(negedge clk);
    expect_ev(0, 0, 0, 4);
    send_byte(8'h45);

    expect_ev(2, 8, 3, 4);
    send_byte(8'hE0);
    send_byte(8'h6B);
    expect_ev(2, 0, 3, 4);
    send_byte(8'hE0);
    send_byte(8'h72);
    send_byte(8'h1C);
    expect_ev(0, 0, 0, 4);
    send_byte(8'h66);
    expect_ev(0, 5, 0, 4);
    send_byte(8'h2E);

    send_bits(frame(8'h46, 1'b0, 1'b1), 5);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_row", int'(bus.cursor_row), 4);
    chk("midreset_col", int'(bus.cursor_col), 4);
    expect_ev(0, 9, 0, 4);
    send_byte(8'h46);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_game_input.md
PS2_GAME_INPUT -- requirements
Module: ps2_game_input

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the clk cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge only.
REQ-003 reset  input  1  SHALL be synchronous and active-high.
REQ-004 ps2_clk  input  1  keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  keyboard data, asynchronous to clk.
REQ-006 cursor_row  output  4  cursor row, range 0..8.
REQ-007 cursor_col  output  4  cursor column, range 0..8.
REQ-008 digit_valid  output  1  one-cycle pulse: digit entry event.
REQ-009 digit_value  output  4  digit entered, 0..9 (0 = clear cell); held until the next digit event.
REQ-010 frame_error  output  1  one-cycle pulse: malformed or timed-out frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be synchronized ps2_clk previous=1, current=0.
REQ-012 All frame bits SHALL be sampled from synchronized ps2_data in the cycle the falling edge is detected.
REQ-013 Receive FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on an edge with data=0 -> DATA with bit count 0; on an edge with data=1 -> stay in IDLE, no error.
REQ-015 DATA: shift in 8 bits, LSB first, one bit per edge; after the 8th bit -> PARITY.
REQ-016 PARITY: capture the bit; data bits plus parity SHALL have odd parity.
REQ-017 STOP: stop bit SHALL be 1; parity OK and stop=1 -> internal byte_valid pulse in the next cycle; otherwise frame_error pulse in the next cycle and the byte is discarded; either case -> IDLE.
REQ-018 Timeout counter SHALL clear on every falling edge and in IDLE; reaching TIMEOUT_CYCLES outside IDLE -> IDLE plus a one-cycle frame_error pulse; partial byte discarded.
REQ-019 Decoder flags brk and ext, both cleared on reset.
  - byte F0: set brk.
  - byte E0: set ext.
  - any other byte with brk=1: key release; no action; clear both flags.
REQ-020 Make codes with ext=1: 75 up, 72 down, 6B left, 74 right; any other extended code is ignored.
REQ-021 Make codes with ext=0: 16,1E,26,25,2E,36,3D,3E,46 = digits 1..9; 45 = 0; 66 (backspace) = 0. Any other code is ignored.
REQ-022 Every non-prefix byte SHALL clear brk and ext after it is decoded.
REQ-023 Up SHALL decrement cursor_row with 0->8 wrap; down SHALL increment it with 8->0 wrap.
REQ-024 Left and right SHALL do the same on cursor_col.
REQ-025 Values outside 0..8 SHALL never appear on cursor_row or cursor_col.
REQ-026 Latency: cursor update and digit_valid/digit_value SHALL appear exactly 1 cycle after byte_valid, i.e. 2 cycles after the stop-bit edge is detected.
REQ-027 Typematic repeats (same make code repeated with no break) SHALL each act, e.g. a held arrow moves the cursor repeatedly.
REQ-028 At most one action SHALL occur per byte; cursor and digit events SHALL never coincide.

Reset
REQ-029 While reset=1, on the next clk edge:
  - FSM -> IDLE; bit count, timeout counter, brk and ext cleared.
  - cursor_row=4, cursor_col=4.
  - digit_valid=0, digit_value=0, frame_error=0.
  - synchronizer flops -> 1.
REQ-030 Reset mid-frame SHALL discard the partial frame with no frame_error; the next frame SHALL decode normally.

Verification
REQ-031 Frame 0x16, parity 0, stop 1 -> digit_valid single pulse, digit_value=1, two cycles after the stop edge; cursor stays (4,4).
REQ-032 Bytes E0 75 sent 5 times from reset -> cursor_row 3,2,1,0,8; cursor_col=4.
REQ-033 Bytes E0 F0 74 (right release) -> no cursor change, no digit_valid; a following 0x1E -> digit_value=2.
REQ-034 0x26 sent with parity bit 1 -> frame_error pulse, no digit_valid; same for stop bit 0.
REQ-035 Start bit plus 3 data bits, then idle for TIMEOUT_CYCLES -> one frame_error pulse, FSM in IDLE; a following 0x45 frame -> digit_valid, digit_value=0.
REQ-036 reset asserted after the 4th data bit of 0x46 -> no events; the next full 0x46 frame -> digit_value=9.
